// File: rtl/bus_interface_ack_pkg.sv
// Shared host-bus encodings, access state type and byte-lane helper for the bus slave.
// Pure declarations: no latency, no backpressure.
package bus_interface_ack_pkg;

  localparam logic CS_ENABLED  = 1'b0;
  localparam logic CS_DISABLED = 1'b1;
  localparam logic RnW_WRITE   = 1'b0;
  localparam logic RnW_READ    = 1'b1;
  localparam logic DTACK_ACK   = 1'b0;
  localparam logic DTACK_NAK   = 1'b1;
  localparam logic BYTE_EVEN   = 1'b0;
  localparam logic BYTE_ODD    = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } bus_state_t;

  // Even byte is the high half of the word, odd byte the low half.
  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic bytesel);
    return (bytesel == BYTE_ODD) ? word[7:0] : word[15:8];
  endfunction

endpackage

// File: rtl/bus_interface_ack_if.sv
// Host bus pin bundle between the external 8-bit host and the bus slave.
// Wires only: no latency; the host is throttled solely by dtack.
interface bus_interface_ack_if #(
  parameter int REG_BITS = 4
);
  logic                cs_n;
  logic                rd_nwr;
  logic [REG_BITS-1:0] reg_num;
  logic                bytesel;
  logic [7:0]          wdata;
  logic [7:0]          rdata;
  logic                data_oe;
  logic                dtack;

  modport master (
    output cs_n, rd_nwr, reg_num, bytesel, wdata,
    input  rdata, data_oe, dtack
  );

  modport slave (
    input  cs_n, rd_nwr, reg_num, bytesel, wdata,
    output rdata, data_oe, dtack
  );
endinterface

// File: rtl/bus_interface_ack_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous bus inputs, with a configurable reset value.
// Latency STAGES clk edges; no backpressure.
module bus_interface_ack_sync #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/bus_interface_ack.sv
// Host bus slave: synchronised CS qualification, byte/word strobes, DTACK from register ack or timeout.
// Strobe SYNC_STAGES+CS_FILTER edges after CS; host held off by DTACK NAK until ack_i or timeout.
module bus_interface_ack
  import bus_interface_ack_pkg::*;
#(
  parameter int REG_BITS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CS_FILTER   = 1,
  parameter int ACK_TIMEOUT = 15,
  parameter int PAIR_EN     = 1
) (
  input  logic                clk,
  input  logic                reset_n_i,
  bus_interface_ack_if.slave  bus,
  output logic                write_strobe_o,
  output logic                read_strobe_o,
  output logic                word_strobe_o,
  output logic [REG_BITS-1:0] reg_num_o,
  output logic                bytesel_o,
  output logic [7:0]          bytedata_o,
  output logic [15:0]         worddata_o,
  input  logic                ack_i,
  input  logic [15:0]         rd_word_i,
  output logic                timeout_o,
  output logic                err_sticky_o,
  input  logic                err_clr_i
);

  localparam int CNT_W = $clog2(CS_FILTER + 1);
  localparam int TO_W  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CS_FILTER);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_ACK  = ACK;

  logic                cs_n_s;
  logic                rd_nwr_s;
  logic [REG_BITS-1:0] reg_s;
  logic                bsel_s;
  logic [7:0]          data_s;

  bus_interface_ack_sync #(
    .WIDTH   (2),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ({CS_DISABLED, RnW_READ})
  ) u_sync_ctl (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .d_i       ({bus.cs_n, bus.rd_nwr}),
    .q_o       ({cs_n_s, rd_nwr_s})
  );

  bus_interface_ack_sync #(
    .WIDTH   (REG_BITS + 9),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ({(REG_BITS + 9){1'b0}})
  ) u_sync_dat (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .d_i       ({bus.reg_num, bus.bytesel, bus.wdata}),
    .q_o       ({reg_s, bsel_s, data_s})
  );

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                armed_q;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                tmo_q, tmo_d;
  logic                err_q;
  logic                rd_nwr_q;
  logic                wstb_q, rstb_q, word_stb_q;
  logic [REG_BITS-1:0] reg_q;
  logic                bsel_q;
  logic [7:0]          byte_q;
  logic [15:0]         word_q;
  logic                pend_q;
  logic [7:0]          even_byte_q;
  logic [REG_BITS-1:0] even_reg_q;

  logic cs_en;
  logic start;
  logic tmo_hit;

  assign cs_en   = (cs_n_s == CS_ENABLED);
  // The current synced sample counts toward the filter, so the strobe lands one edge earlier.
  assign start   = (state_q == S_IDLE) && armed_q && cs_en && ((int'(cnt_q) + 1) == CS_FILTER);
  assign tmo_hit = (ACK_TIMEOUT != 0) && ((int'(to_cnt_q) + 1) == ACK_TIMEOUT);

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    rdata_d  = rdata_q;
    tmo_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_WAIT;
          to_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (!cs_en) begin
          state_d = S_IDLE;
        end else if (ack_i) begin
          state_d = S_ACK;
          if (rd_nwr_q == RnW_READ) rdata_d = pick_byte(rd_word_i, bsel_q);
        end else if (tmo_hit) begin
          state_d = S_ACK;
          tmo_d   = 1'b1;
          if (rd_nwr_q == RnW_READ) rdata_d = 8'hFF;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        // Release watches the raw pin so the host sees DTACK drop without sync delay.
        if (bus.cs_n == CS_DISABLED) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      to_cnt_q <= '0;
      rdata_q  <= '0;
      tmo_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      rdata_q  <= rdata_d;
      tmo_q    <= tmo_d;
      if (!cs_en) begin
        cnt_q   <= '0;
        armed_q <= 1'b1;
      end else begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        if (start) armed_q <= 1'b0;
      end
      if (tmo_d) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_nwr_q    <= 1'b0;
      wstb_q      <= 1'b0;
      rstb_q      <= 1'b0;
      word_stb_q  <= 1'b0;
      reg_q       <= '0;
      bsel_q      <= 1'b0;
      byte_q      <= '0;
      word_q      <= '0;
      pend_q      <= 1'b0;
      even_byte_q <= '0;
      even_reg_q  <= '0;
    end else begin
      wstb_q     <= 1'b0;
      rstb_q     <= 1'b0;
      word_stb_q <= 1'b0;
      if (start) begin
        reg_q    <= reg_s;
        bsel_q   <= bsel_s;
        byte_q   <= data_s;
        rd_nwr_q <= rd_nwr_s;
        if (rd_nwr_s == RnW_READ) begin
          rstb_q <= 1'b1;
        end else begin
          wstb_q <= 1'b1;
          if (PAIR_EN != 0) begin
            if (bsel_s == BYTE_EVEN) begin
              even_byte_q <= data_s;
              even_reg_q  <= reg_s;
              pend_q      <= 1'b1;
            end else if (pend_q && (reg_s == even_reg_q)) begin
              word_stb_q <= 1'b1;
              word_q     <= {even_byte_q, data_s};
              pend_q     <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign bus.dtack    = (state_q == S_ACK) ? DTACK_ACK : DTACK_NAK;
  assign bus.data_oe  = (state_q == S_ACK) && (rd_nwr_q == RnW_READ);
  assign bus.rdata    = rdata_q;

  assign write_strobe_o = wstb_q;
  assign read_strobe_o  = rstb_q;
  assign word_strobe_o  = word_stb_q;
  assign reg_num_o      = reg_q;
  assign bytesel_o      = bsel_q;
  assign bytedata_o     = byte_q;
  assign worddata_o     = word_q;
  assign timeout_o      = tmo_q;
  assign err_sticky_o   = err_q;

endmodule

// File: tb/tb_bus_interface_ack.sv
// Directed bench for bus_interface_ack (SYNC_STAGES=2, CS_FILTER=2, ACK_TIMEOUT=15, PAIR_EN=1).
// Inputs change and outputs are sampled 1 time unit after each rising clk edge.
module tb_bus_interface_ack;
  import bus_interface_ack_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        write_strobe, read_strobe, word_strobe;
  logic [3:0]  reg_num;
  logic        bytesel;
  logic [7:0]  bytedata;
  logic [15:0] worddata;
  logic        ack = 1'b0;
  logic [15:0] rd_word = 16'h0000;
  logic        timeout, err_sticky;
  logic        err_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  bus_interface_ack_if #(.REG_BITS(4)) bif ();

  bus_interface_ack #(
    .REG_BITS(4), .SYNC_STAGES(2), .CS_FILTER(2), .ACK_TIMEOUT(15), .PAIR_EN(1)
  ) dut (
    .clk            (clk),
    .reset_n_i      (reset_n),
    .bus            (bif.slave),
    .write_strobe_o (write_strobe),
    .read_strobe_o  (read_strobe),
    .word_strobe_o  (word_strobe),
    .reg_num_o      (reg_num),
    .bytesel_o      (bytesel),
    .bytedata_o     (bytedata),
    .worddata_o     (worddata),
    .ack_i          (ack),
    .rd_word_i      (rd_word),
    .timeout_o      (timeout),
    .err_sticky_o   (err_sticky),
    .err_clr_i      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic rnw, input logic [3:0] rn, input logic bs, input logic [7:0] d);
    bif.rd_nwr  = rnw;
    bif.reg_num = rn;
    bif.bytesel = bs;
    bif.wdata   = d;
    bif.cs_n    = CS_ENABLED;
  endtask

  // Edge index (counted from the first edge sampling CS low) of the first strobe, -1 if none.
  task automatic wait_strobe(output int edge_n, output logic w, output logic r, output logic wd);
    edge_n = -1; w = 1'b0; r = 1'b0; wd = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (write_strobe || read_strobe) begin
        edge_n = i; w = write_strobe; r = read_strobe; wd = word_strobe;
        break;
      end
    end
  endtask

  task automatic ack_after(input int dly);
    repeat (dly) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic release_cs();
    bif.cs_n = CS_DISABLED;
    tick();
  endtask

  task automatic test_reset();
    bif.cs_n = CS_DISABLED; bif.rd_nwr = RnW_READ; bif.reg_num = 4'd0; bif.bytesel = 1'b0; bif.wdata = 8'h00;
    reset_n = 1'b0;
    idle(3);
    checks++; if (bif.dtack !== DTACK_NAK) begin errors++; $display("FAIL reset_dtack: got %b want %b", bif.dtack, DTACK_NAK); end
    checks++; if ({write_strobe, read_strobe, word_strobe, timeout, err_sticky, bif.data_oe} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {write_strobe, read_strobe, word_strobe, timeout, err_sticky, bif.data_oe}); end
    checks++; if ({bif.rdata, reg_num, bytedata, worddata} !== 36'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {bif.rdata, reg_num, bytedata, worddata}); end
    reset_n = 1'b1;
    idle(4);
    checks++; if (bif.dtack !== DTACK_NAK) begin errors++; $display("FAIL post_reset_dtack: got %b want %b", bif.dtack, DTACK_NAK); end
  endtask

  task automatic test_write();
    int e; logic w, r, wd;
    drive(RnW_WRITE, 4'd3, BYTE_EVEN, 8'hA5);
    wait_strobe(e, w, r, wd);
    checks++; if (e !== 4) begin errors++; $display("FAIL wr_latency: got %0d want 4", e); end
    checks++; if ({w, r} !== 2'b10) begin errors++; $display("FAIL wr_strobes: got %b want 10", {w, r}); end
    checks++; if ({reg_num, bytesel, bytedata} !== {4'd3, 1'b0, 8'hA5}) begin
      errors++; $display("FAIL wr_capture: got %h want %h", {reg_num, bytesel, bytedata}, {4'd3, 1'b0, 8'hA5}); end
    checks++; if (bif.dtack !== DTACK_NAK) begin errors++; $display("FAIL wr_dtack_wait: got %b want %b", bif.dtack, DTACK_NAK); end
    ack_after(2);
    checks++; if ({bif.dtack, bif.data_oe, write_strobe} !== {DTACK_ACK, 2'b00}) begin
      errors++; $display("FAIL wr_ack: got %b want %b", {bif.dtack, bif.data_oe, write_strobe}, {DTACK_ACK, 2'b00}); end
    release_cs();
    checks++; if (bif.dtack !== DTACK_NAK) begin errors++; $display("FAIL wr_release: got %b want %b", bif.dtack, DTACK_NAK); end
    idle(4);
  endtask

  task automatic test_pairing();
    int e; logic w, r, wd;
    drive(RnW_WRITE, 4'd5, BYTE_EVEN, 8'h12);
    wait_strobe(e, w, r, wd); ack_after(0); release_cs(); idle(4);
    checks++; if ({w, wd} !== 2'b10) begin errors++; $display("FAIL pair_even: got %b want 10", {w, wd}); end
    drive(RnW_WRITE, 4'd5, BYTE_ODD, 8'h34);
    wait_strobe(e, w, r, wd);
    checks++; if ({w, wd} !== 2'b11) begin errors++; $display("FAIL pair_odd: got %b want 11", {w, wd}); end
    checks++; if (worddata !== 16'h1234) begin errors++; $display("FAIL pair_word: got %h want 1234", worddata); end
    ack_after(0); release_cs(); idle(4);
    drive(RnW_WRITE, 4'd7, BYTE_EVEN, 8'h77);
    wait_strobe(e, w, r, wd); ack_after(0); release_cs(); idle(4);
    drive(RnW_WRITE, 4'd6, BYTE_ODD, 8'h88);
    wait_strobe(e, w, r, wd);
    checks++; if ({w, wd, worddata} !== {2'b10, 16'h1234}) begin
      errors++; $display("FAIL pair_mismatch: got %h want %h", {w, wd, worddata}, {2'b10, 16'h1234}); end
    ack_after(0); release_cs(); idle(4);
  endtask

  task automatic test_read();
    int e; logic w, r, wd;
    drive(RnW_WRITE, 4'd9, BYTE_EVEN, 8'h9A);
    wait_strobe(e, w, r, wd); ack_after(0); release_cs(); idle(4);
    rd_word = 16'hBEEF;
    drive(RnW_READ, 4'd2, BYTE_ODD, 8'h00);
    wait_strobe(e, w, r, wd);
    checks++; if ({w, r} !== 2'b01) begin errors++; $display("FAIL rd_strobes: got %b want 01", {w, r}); end
    ack_after(1);
    checks++; if ({bif.dtack, bif.data_oe, bif.rdata} !== {DTACK_ACK, 1'b1, 8'hEF}) begin
      errors++; $display("FAIL rd_odd: got %h want %h", {bif.dtack, bif.data_oe, bif.rdata}, {DTACK_ACK, 1'b1, 8'hEF}); end
    release_cs();
    checks++; if ({bif.dtack, bif.data_oe} !== {DTACK_NAK, 1'b0}) begin
      errors++; $display("FAIL rd_release: got %b want %b", {bif.dtack, bif.data_oe}, {DTACK_NAK, 1'b0}); end
    idle(4);
    drive(RnW_READ, 4'd2, BYTE_EVEN, 8'h00);
    wait_strobe(e, w, r, wd); ack_after(1);
    checks++; if (bif.rdata !== 8'hBE) begin errors++; $display("FAIL rd_even: got %h want be", bif.rdata); end
    release_cs(); idle(4);
    drive(RnW_WRITE, 4'd9, BYTE_ODD, 8'hBC);
    wait_strobe(e, w, r, wd);
    checks++; if ({wd, worddata} !== {1'b1, 16'h9ABC}) begin
      errors++; $display("FAIL rd_keeps_pending: got %h want %h", {wd, worddata}, {1'b1, 16'h9ABC}); end
    ack_after(0); release_cs(); idle(4);
  endtask

  task automatic test_timeout();
    int e, n; logic w, r, wd, tmo_seen;
    drive(RnW_READ, 4'd1, BYTE_EVEN, 8'h00);
    wait_strobe(e, w, r, wd);
    n = -1; tmo_seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bif.dtack === DTACK_ACK) begin n = i; tmo_seen = timeout; break; end
    end
    checks++; if (n !== 15) begin errors++; $display("FAIL tmo_cycles: got %0d want 15", n); end
    checks++; if ({tmo_seen, bif.data_oe, bif.rdata} !== {2'b11, 8'hFF}) begin
      errors++; $display("FAIL tmo_ack: got %h want %h", {tmo_seen, bif.data_oe, bif.rdata}, {2'b11, 8'hFF}); end
    tick();
    checks++; if ({timeout, err_sticky} !== 2'b01) begin errors++; $display("FAIL tmo_pulse: got %b want 01", {timeout, err_sticky}); end
    release_cs(); idle(4);
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL err_hold: got %b want 1", err_sticky); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err_sticky); end
    // ack_i arriving on the exact timeout cycle
    drive(RnW_WRITE, 4'd1, BYTE_ODD, 8'h01);
    wait_strobe(e, w, r, wd);
    ack_after(14);
    checks++; if ({bif.dtack, timeout, err_sticky} !== {DTACK_ACK, 2'b00}) begin
      errors++; $display("FAIL ack_wins: got %b want %b", {bif.dtack, timeout, err_sticky}, {DTACK_ACK, 2'b00}); end
    release_cs(); idle(4);
    // clear held high across a timeout: set wins, then clear applies
    err_clr = 1'b1;
    drive(RnW_WRITE, 4'd1, BYTE_ODD, 8'h02);
    wait_strobe(e, w, r, wd);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bif.dtack === DTACK_ACK) begin n = i; break; end
    end
    checks++; if ({n == 15, err_sticky} !== 2'b11) begin errors++; $display("FAIL err_set_wins: got n=%0d err=%b want n=15 err=1", n, err_sticky); end
    tick();
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL err_clr_after: got %b want 0", err_sticky); end
    err_clr = 1'b0;
    release_cs(); idle(4);
  endtask

  task automatic test_glitch();
    int cnt; logic acked;
    drive(RnW_WRITE, 4'd4, BYTE_EVEN, 8'h44);
    tick();
    bif.cs_n = CS_DISABLED;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (write_strobe || read_strobe) cnt++; end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL glitch_1cyc: got %0d strobes want 0", cnt); end
    // two synced samples pass the filter, then the early release aborts the access
    drive(RnW_WRITE, 4'd4, BYTE_EVEN, 8'h44);
    tick(); tick();
    bif.cs_n = CS_DISABLED;
    cnt = 0; acked = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (write_strobe) cnt++;
      if (bif.dtack === DTACK_ACK) acked = 1'b1;
    end
    checks++; if ({cnt == 1, acked, err_sticky} !== 3'b100) begin
      errors++; $display("FAIL bus_abort: got strobes=%0d acked=%b err=%b want 1 0 0", cnt, acked, err_sticky); end
  endtask

  task automatic test_cs_held();
    int e, cnt; logic w, r, wd, held;
    drive(RnW_WRITE, 4'd8, BYTE_ODD, 8'h08);
    wait_strobe(e, w, r, wd);
    ack_after(0);
    cnt = 0; held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (write_strobe || read_strobe) cnt++;
      if (bif.dtack !== DTACK_ACK) held = 1'b0;
    end
    checks++; if ({cnt == 0, held} !== 2'b11) begin
      errors++; $display("FAIL cs_held: got strobes=%0d held=%b want 0 1", cnt, held); end
    release_cs();
    checks++; if (bif.dtack !== DTACK_NAK) begin errors++; $display("FAIL cs_held_release: got %b want %b", bif.dtack, DTACK_NAK); end
    idle(4);
  endtask

  task automatic test_reset_mid();
    int e; logic w, r, wd;
    drive(RnW_WRITE, 4'd3, BYTE_EVEN, 8'h11);
    wait_strobe(e, w, r, wd);
    reset_n = 1'b0; #1;
    checks++; if ({bif.dtack, bif.data_oe, write_strobe, read_strobe, word_strobe} !== {DTACK_NAK, 4'b0000}) begin
      errors++; $display("FAIL rst_wait: got %b want %b", {bif.dtack, bif.data_oe, write_strobe, read_strobe, word_strobe}, {DTACK_NAK, 4'b0000}); end
    bif.cs_n = CS_DISABLED; tick(); reset_n = 1'b1; idle(4);
    rd_word = 16'h1357;
    drive(RnW_READ, 4'd2, BYTE_ODD, 8'h00);
    wait_strobe(e, w, r, wd); ack_after(0);
    checks++; if ({bif.data_oe, bif.rdata} !== {1'b1, 8'h57}) begin
      errors++; $display("FAIL rst_pre_ack: got %h want %h", {bif.data_oe, bif.rdata}, {1'b1, 8'h57}); end
    reset_n = 1'b0; #1;
    checks++; if ({bif.dtack, bif.data_oe, bif.rdata} !== {DTACK_NAK, 1'b0, 8'h00}) begin
      errors++; $display("FAIL rst_ack: got %h want %h", {bif.dtack, bif.data_oe, bif.rdata}, {DTACK_NAK, 1'b0, 8'h00}); end
    bif.cs_n = CS_DISABLED; tick(); reset_n = 1'b1; idle(4);
    drive(RnW_WRITE, 4'd3, BYTE_EVEN, 8'h22);
    wait_strobe(e, w, r, wd);
    checks++; if ({e == 4, w, bytedata} !== {2'b11, 8'h22}) begin
      errors++; $display("FAIL rst_clean: got edge=%0d w=%b data=%h want 4 1 22", e, w, bytedata); end
    ack_after(0);
    checks++; if (bif.dtack !== DTACK_ACK) begin errors++; $display("FAIL rst_clean_ack: got %b want %b", bif.dtack, DTACK_ACK); end
    release_cs(); idle(4);
  endtask

  initial begin
    test_reset();
    test_write();
    test_pairing();
    test_read();
    test_timeout();
    test_glitch();
    test_cs_held();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
